twofish_stream_ctrl: RTL
========================

# twofish_stream_ctrl

Word-stream front/back end for the Twofish `datapath` core. It packs four 32-bit input words into a 128-bit block and optionally XORs it for CBC chaining. It launches the core with a one-cycle `Start`, waits for `busy` to fall, and returns the 128-bit result as four 32-bit output words. It sits directly upstream and downstream of `datapath`: it drives `block`, `key`, `Start` and `EnDe`, and consumes `o` and `busy`.

## Interface
- `CBC_EN`, default 1: 1 enables CBC chaining logic; 0 hardwires ECB (chain register and XORs removed).
- `Clk` in 1: single clock for the whole block.
- `Reset` in 1: asynchronous, active-high; clears all state.
- `cfg_load` in 1: one-cycle pulse that loads `cfg_key`, `cfg_iv`, `cfg_ende` and `cfg_cbc`. Honoured only in FILL with `fill_cnt==0`; ignored otherwise.
- `cfg_key` in 128: cipher key, registered on `cfg_load`.
- `cfg_iv` in 128: initial chain value, registered into `chain` on `cfg_load`.
- `cfg_ende` in 1: 0 = encrypt, 1 = decrypt; registered.
- `cfg_cbc` in 1: 1 = CBC mode, 0 = ECB; registered and forced to 0 when `CBC_EN=0`.
- `in_data` in 32: input word. Word 0 of a block maps to bits [127:96].
- `in_valid` in 1 / `in_ready` out 1: input handshake. A word transfers when both are 1 on a rising edge.
- `out_data` out 32: output word, in the same word order as the input.
- `out_valid` out 1 / `out_ready` in 1: output handshake.
- `dp_block` out 128: driven to datapath `block`.
- `dp_key` out 128: driven to datapath `key` (the registered key).
- `dp_Start` out 1: driven to datapath `Start`.
- `dp_EnDe` out 1: driven to datapath `EnDe` (the registered `cfg_ende`).
- `dp_o` in 128: datapath result.
- `dp_busy` in 1: datapath busy.
- `idle` out 1: 1 in FILL with `fill_cnt==0`.

## Operation
- **States:** FILL, START, ARM, WAIT, DRAIN.
- **FILL:**
  - `in_ready=1`. Each transfer shifts the word into `buf` (`buf <= {buf[95:0], in_data}`) and increments the 2-bit `fill_cnt`.
  - On the 4th transfer (`fill_cnt==3`), `fill_cnt` wraps to 0 and the state goes to START.
  - `dp_block` is registered on that same edge:
    - encrypt with CBC: `{buf[95:0],in_data} ^ chain`;
    - otherwise: `{buf[95:0],in_data}`.
  - The raw assembled block is also kept in `raw`.
- **START:** `dp_Start=1` for exactly one cycle, then ARM.
- **ARM:** one cycle during which `dp_busy` is ignored, then WAIT.
- **WAIT:**
  - On the first cycle with `dp_busy==0`, register `res` from `dp_o` and go to DRAIN:
    - decrypt with CBC: `res = dp_o ^ chain`;
    - otherwise: `res = dp_o`.
  - Chain update on that edge, CBC only:
    - encrypt: `chain <= dp_o`;
    - decrypt: `chain <= raw`.
- **DRAIN:**
  - `out_valid=1`, `out_data = res[127:96]`.
  - Each output transfer shifts `res` left by 32 and increments `drain_cnt`.
  - After the 4th transfer, `drain_cnt` wraps to 0 and the state returns to FILL.
- `in_ready=0` in every state except FILL; no input words are accepted while a block is in flight or draining.
- `cfg_load` outside FILL, or in FILL with `fill_cnt!=0`, is ignored with no side effects.
- `dp_key` and `dp_EnDe` change only on an honoured `cfg_load`, and so stay stable for the whole duration of a block.

## Timing
- **Reset values:**
  - state = FILL; `fill_cnt`, `drain_cnt`, `buf`, `raw`, `res`, `chain`, key = 0;
  - `cfg_ende=0`, `cfg_cbc=0`;
  - `in_ready=1`, `out_valid=0`, `out_data=0`, `dp_Start=0`, `dp_block=0`, `idle=1`.
- **Reset mid-block:** all of the above take effect immediately, asynchronously. Any partial block and any pending output are discarded. `dp_Start` drops at once.
- **Cycle timing:**
  - `dp_Start` rises in the cycle after the 4th input transfer.
  - The earliest `res` capture is 2 cycles after the `dp_Start` cycle.
  - The first `out_valid` is in the cycle after capture.
- **Latency (4th input word to first output word):** 3 + N cycles, where N is the number of cycles `dp_busy` stays high after ARM.
- **Throughput:** with `out_ready` held at 1, DRAIN takes exactly 4 cycles.
- `out_valid` stays high and `out_data` stays stable while `out_ready=0` (no word is lost or duplicated).
- Simultaneous `cfg_load` and `in_valid` in FILL with `fill_cnt==0`: the config is loaded, and the word is accepted as word 0 of a block that uses the new config (XORed with the new IV).

## Test plan
- **ECB encrypt, zero vector:** `cfg_load` with key=0, `ende=0`, `cbc=0`; send 4 words of 0. The output words must be 9F589F5C, F6122C32, B6BFEC2F, 2AE8C35A.
- **ECB decrypt:** same key, `ende=1`; send the 4 ciphertext words from the zero-vector case. The output must be 4×00000000.
- **CBC round trip:** key=0, IV=00112233_44556677_8899AABB_CCDDEEFF; encrypt two blocks P1=0 and P2=1. Then reload the same IV with `ende=1` and decrypt C1, C2. The decrypted output must equal P1, P2 word-exact, and C1 must differ from the ECB encryption of P1.
- **Backpressure:** hold `out_ready=0` for 10 cycles during DRAIN, then toggle it every other cycle. Require 4 words in order, `out_valid` high throughout, `in_ready=0` until the 4th output transfer.
- **Ignored config:** pulse `cfg_load` with key=FF..FF after 2 input words. The block must still use the old key: zero input with zero key produces the zero-vector result.
- **Async reset mid-flight:** assert `Reset` during WAIT. In the same cycle, `dp_Start=0`, `out_valid=0`, `in_ready=1`, `idle=1`. The next full block must produce correct ECB output with key 0.

Source files
------------

// File: rtl/twofish_stream_ctrl.sv
// Word-stream front/back end for the Twofish datapath: packs 4x32b words into a block,
// applies optional CBC chaining, runs the core and unpacks the result with a valid/ready handshake.
module twofish_stream_ctrl #(
  parameter int CBC_EN = 1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         cfg_load,
  input  logic [127:0] cfg_key,
  input  logic [127:0] cfg_iv,
  input  logic         cfg_ende,
  input  logic         cfg_cbc,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dp_block,
  output logic [127:0] dp_key,
  output logic         dp_Start,
  output logic         dp_EnDe,
  input  logic [127:0] dp_o,
  input  logic         dp_busy,
  output logic         idle
);

  localparam logic CbcOn = (CBC_EN != 0);

  typedef enum logic [2:0] {
    S_FILL,
    S_START,
    S_ARM,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e       state_q;
  logic [1:0]   fill_cnt_q;
  logic [1:0]   drain_cnt_q;
  logic [127:0] blk_buf_q;
  logic [127:0] raw_q;
  logic [127:0] res_q;
  logic [127:0] chain_q;
  logic [127:0] key_q;
  logic [127:0] block_q;
  logic         ende_q;
  logic         cbc_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         start_q;
  logic         idle_q;

  logic [127:0] blk_d;
  logic         cfg_take;
  logic         in_xfer;
  logic         out_xfer;

  assign blk_d    = {blk_buf_q[95:0], in_data};
  assign cfg_take = cfg_load && (state_q == S_FILL) && (fill_cnt_q == 2'd0);
  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_ready && out_valid_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_FILL;
      fill_cnt_q  <= 2'd0;
      drain_cnt_q <= 2'd0;
      blk_buf_q   <= '0;
      raw_q       <= '0;
      res_q       <= '0;
      chain_q     <= '0;
      key_q       <= '0;
      block_q     <= '0;
      ende_q      <= 1'b0;
      cbc_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      start_q     <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      case (state_q)
        S_FILL: begin
          // Config lands before any word of the block is buffered, so a word
          // arriving on the same edge already belongs to the new configuration.
          if (cfg_take) begin
            key_q  <= cfg_key;
            ende_q <= cfg_ende;
            cbc_q  <= cfg_cbc && CbcOn;
            if (CbcOn) chain_q <= cfg_iv;
          end
          if (in_xfer) begin
            blk_buf_q  <= blk_d;
            fill_cnt_q <= fill_cnt_q + 2'd1;
            idle_q     <= 1'b0;
            if (fill_cnt_q == 2'd3) begin
              raw_q      <= blk_d;
              block_q    <= (cbc_q && !ende_q) ? (blk_d ^ chain_q) : blk_d;
              start_q    <= 1'b1;
              in_ready_q <= 1'b0;
              state_q    <= S_START;
            end
          end
        end
        S_START: begin
          start_q <= 1'b0;
          state_q <= S_ARM;
        end
        // The core may not have raised busy yet, so busy is not trusted here.
        S_ARM: state_q <= S_WAIT;
        S_WAIT: begin
          if (!dp_busy) begin
            res_q       <= (cbc_q && ende_q) ? (dp_o ^ chain_q) : dp_o;
            if (cbc_q && CbcOn) chain_q <= ende_q ? raw_q : dp_o;
            out_valid_q <= 1'b1;
            state_q     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_xfer) begin
            res_q       <= {res_q[95:0], 32'h0};
            drain_cnt_q <= drain_cnt_q + 2'd1;
            if (drain_cnt_q == 2'd3) begin
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              idle_q      <= 1'b1;
              state_q     <= S_FILL;
            end
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = res_q[127:96];
  assign dp_block  = block_q;
  assign dp_key    = key_q;
  assign dp_Start  = start_q;
  assign dp_EnDe   = ende_q;
  assign idle      = idle_q;

endmodule
